// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame link (serializer and receiver).
//   - frame_state_t and the ST_* encodings used by the receiver FSM
//   - line-level constants: START_BIT, STOP_BIT, IDLE_LEVEL
//   - even_parity(): XOR-reduce of up to PARITY_MAX_W bits
package serial_frame_pkg;

  typedef logic [2:0] frame_state_t;

  localparam frame_state_t ST_IDLE     = 3'd0;
  localparam frame_state_t ST_START    = 3'd1;
  localparam frame_state_t ST_DATA     = 3'd2;
  localparam frame_state_t ST_PARITY   = 3'd3;
  localparam frame_state_t ST_STOP     = 3'd4;
  localparam frame_state_t ST_WAIT_LOW = 3'd5;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

  // Words narrower than this are zero-extended by the caller, which
  // leaves the parity unchanged.
  localparam int PARITY_MAX_W = 64;

  // Returns the even-parity bit: 1 when the word holds an odd number of ones.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] bits_i);
    return ^bits_i;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer for the serial receiver.
// Ports:
//   clock_i    system clock
//   reset_i    synchronous active-high reset, clears the count
//   restart_i  clears the count (held while the line is idle)
//   load_i     loads HALF so the first strobe lands mid start bit
//   sample_o   one-cycle strobe every CLKS_PER_BIT cycles
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic restart_i,
  input  logic load_i,
  output logic sample_o
);

  localparam int            TW     = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_V = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] LAST_V = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // Loading HALF (rather than 0) at start detect makes the strobe fire
  // HALF cycles later, i.e. in the middle of the start bit; from then on
  // every strobe falls mid-bit.
  assign sample_o = (cnt_q == LAST_V);

  always_comb begin
    cnt_d = cnt_q + TW'(1);
    if (sample_o) cnt_d = '0;
    if (restart_i) cnt_d = '0;
    if (load_i) cnt_d = HALF_V;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit (1), DATA_W data bits MSB first, even
// parity bit, stop bit (0). Each frame is delivered as a parallel word
// with a one-cycle valid strobe; errored frames are still delivered.
// Ports:
//   clock_i       system clock
//   reset_i       synchronous active-high reset
//   in_i          serial line (idles low)
//   data_o        last received word, held until the next valid
//   valid_o       one-cycle pulse when data_o and the flags update
//   parity_err_o  parity mismatch of the last frame
//   frame_err_o   stop bit of the last frame sampled high
//   busy_o        high from start detection through the stop-bit sample
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              in_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              busy_o
);

  localparam int            CW       = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  frame_state_t      state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              par_bit_q, par_bit_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;

  logic sample;
  logic timer_restart;
  logic timer_load;

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .restart_i(timer_restart),
    .load_i   (timer_load),
    .sample_o (sample)
  );

  // Frame FSM. Outputs are registered at the stop-bit sample so they change
  // together with the valid pulse; the FSM returns to IDLE at that same edge
  // so a back-to-back start bit is caught with no dead time.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    par_bit_d     = par_bit_q;
    data_d        = data_q;
    perr_d        = perr_q;
    ferr_d        = ferr_q;
    valid_d       = 1'b0;
    timer_restart = 1'b0;
    timer_load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_i == START_BIT) begin
          state_d    = ST_START;
          timer_load = 1'b1;
        end else begin
          timer_restart = 1'b1;
        end
      end
      ST_START: begin
        if (sample) begin
          // A start bit that has vanished by mid-bit is a glitch.
          if (in_i == START_BIT) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (sample) begin
          shift_d   = DATA_W'({shift_q, in_i});
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == LAST_BIT) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (sample) begin
          par_bit_d = in_i;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample) begin
          data_d  = shift_q;
          perr_d  = even_parity(PARITY_MAX_W'(shift_q)) ^ par_bit_q;
          ferr_d  = (in_i != STOP_BIT);
          valid_d = 1'b1;
          // A stuck-high stop bit must drop before a new start is accepted.
          state_d = (in_i != STOP_BIT) ? ST_WAIT_LOW : ST_IDLE;
        end
      end
      ST_WAIT_LOW: begin
        timer_restart = 1'b1;
        if (in_i == IDLE_LEVEL) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_bit_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_bit_q <= par_bit_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign busy_o       = (state_q == ST_START) || (state_q == ST_DATA) ||
                        (state_q == ST_PARITY) || (state_q == ST_STOP);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: frames are driven on the line,
// expected results are queued when a frame starts and compared when valid
// pulses.
module tb_serial_frame_rx;

  localparam int DATA_W = 32;
  localparam int CPB    = 4;
  localparam int HALF   = CPB / 2;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              perr;
    logic              ferr;
    int                vcyc;
  } expT;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              rxIn = 1'b0;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              parityErr;
  logic              frameErr;
  logic              busy;

  int  cyc = 0;
  int  checkCount = 0;
  int  errorCount = 0;
  int  lastValid = 0;
  int  prevValid = 0;
  expT expQ[$];
  expT monE;

  serial_frame_rx #(
    .DATA_W(DATA_W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .in_i        (rxIn),
    .data_o      (data),
    .valid_o     (valid),
    .parity_err_o(parityErr),
    .frame_err_o (frameErr),
    .busy_o      (busy)
  );

  // Free-running clock and an edge counter used to time-stamp valid pulses.
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic driveBit(input logic b);
    rxIn = b;
    repeat (CPB) @(negedge clock);
  endtask

  // Drives one frame starting at the current negedge. With abortBit >= 0 a
  // one-cycle reset is issued during that data bit and nothing is expected.
  task automatic applyStimulus(input logic [DATA_W-1:0] word, input logic parityBit,
                               input logic stopBit, input int abortBit);
    expT e;
    int  t0;
    t0 = cyc + 1;
    if (abortBit < 0) begin
      e.data = word;
      e.perr = (^word) ^ parityBit;
      e.ferr = stopBit;
      e.vcyc = t0 + HALF + (DATA_W + 2) * CPB;
      expQ.push_back(e);
    end
    driveBit(1'b1);
    for (int k = 0; k < DATA_W; k++) begin
      if (k == abortBit) begin
        rxIn  = word[DATA_W-1-k];
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("rst_mid_data", data, 0);
        checkOutput("rst_mid_valid", valid, 0);
        checkOutput("rst_mid_perr", parityErr, 0);
        checkOutput("rst_mid_ferr", frameErr, 0);
        checkOutput("rst_mid_busy", busy, 0);
        rxIn = 1'b0;
        return;
      end
      driveBit(word[DATA_W-1-k]);
    end
    driveBit(parityBit);
    driveBit(stopBit);
  endtask

  // Scoreboard side: every valid must match the oldest queued frame.
  always @(negedge clock) begin
    if (valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_valid", 1, 0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("rx_data", data, monE.data);
        checkOutput("rx_parity_err", parityErr, monE.perr);
        checkOutput("rx_frame_err", frameErr, monE.ferr);
        checkOutput("rx_valid_cycle", cyc, monE.vcyc);
        prevValid = lastValid;
        lastValid = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    reset = 1'b1;
    rxIn  = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_data", data, 0);
    checkOutput("reset_valid", valid, 0);
    checkOutput("reset_perr", parityErr, 0);
    checkOutput("reset_ferr", frameErr, 0);
    checkOutput("reset_busy", busy, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Good frame
    applyStimulus(32'h00000003, 1'b0, 1'b0, -1);
    rxIn = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("pending_good", expQ.size(), 0);

    // Wrong parity bit
    applyStimulus(32'h00000009, 1'b1, 1'b0, -1);
    rxIn = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("pending_parity", expQ.size(), 0);
    checkOutput("perr_held", parityErr, 1);
    checkOutput("data_held", data, 32'h00000009);

    // One-cycle glitch on an idle line
    rxIn = 1'b1;
    @(negedge clock);
    checkOutput("glitch_busy_hi", busy, 1);
    rxIn = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("glitch_busy_lo", busy, 0);
    repeat (3) @(negedge clock);
    applyStimulus(32'h00000005, 1'b0, 1'b0, -1);
    rxIn = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("pending_glitch", expQ.size(), 0);

    // Stop bit stuck high, line held high afterwards
    applyStimulus(32'h0000000A, 1'b0, 1'b1, -1);
    repeat (20) @(negedge clock);
    checkOutput("waitlow_busy", busy, 0);
    checkOutput("waitlow_ferr_held", frameErr, 1);
    rxIn = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("pending_ferr", expQ.size(), 0);

    // Back-to-back frames
    applyStimulus(32'h00000004, 1'b1, 1'b0, -1);
    applyStimulus(32'h00000005, 1'b0, 1'b0, -1);
    rxIn = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("pending_b2b", expQ.size(), 0);
    checkOutput("b2b_gap", lastValid - prevValid, 140);

    // Reset during data bit 10, then a full frame
    applyStimulus(32'h00F0F0F0, 1'b0, 1'b0, 10);
    repeat (8) @(negedge clock);
    checkOutput("post_rst_busy", busy, 0);
    applyStimulus(32'h12345678, 1'b1, 1'b0, -1);
    rxIn = 1'b0;
    repeat (10) @(negedge clock);
    checkOutput("pending_end", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
